// File: rtl/preg_freelist_if.sv
// -----------------------------------------------------------------------------
// preg_freelist_if
//   Bundle of the rename-side and commit-side signals of the physical register
//   free list.
//
//   Modports:
//     master : rename + ROB commit side (drives requests/releases, sees tags)
//     slave  : the free list itself
//
//   Signals:
//     instr0/1_freelist_req   rename slot consumes a PREG this cycle
//     instr0/1_freelist_resp  PREG handed to the slot (combinational)
//     freelist_can_alloc      at least two free entries available
//     commit0/1_alloc_valid   committed instr had a destination
//     commit0/1_free_valid    release the matching commit0/1_free_preg
//     commit0/1_free_preg     old physical destination being released
//     flush_valid             redirect: restore speculative alloc pointer
//     freelist_count          speculative number of free entries
//     dbg_freelist_err        sticky misuse flag (FREELIST_DBG_CHECK_EN only)
//
//   Build option: FREELIST_DBG_CHECK_EN adds dbg_freelist_err.
// -----------------------------------------------------------------------------
interface preg_freelist_if #(
  parameter int PREG_W = 6,
  parameter int CNT_W  = 6
) ();

  logic              instr0_freelist_req;
  logic [PREG_W-1:0] instr0_freelist_resp;
  logic              instr1_freelist_req;
  logic [PREG_W-1:0] instr1_freelist_resp;
  logic              freelist_can_alloc;

  logic              commit0_alloc_valid;
  logic              commit1_alloc_valid;
  logic              commit0_free_valid;
  logic [PREG_W-1:0] commit0_free_preg;
  logic              commit1_free_valid;
  logic [PREG_W-1:0] commit1_free_preg;

  logic              flush_valid;
  logic [CNT_W-1:0]  freelist_count;

`ifdef FREELIST_DBG_CHECK_EN
  logic              dbg_freelist_err;
`endif

  modport master (
`ifdef FREELIST_DBG_CHECK_EN
    input  dbg_freelist_err,
`endif
    output instr0_freelist_req,
    input  instr0_freelist_resp,
    output instr1_freelist_req,
    input  instr1_freelist_resp,
    input  freelist_can_alloc,
    output commit0_alloc_valid,
    output commit1_alloc_valid,
    output commit0_free_valid,
    output commit0_free_preg,
    output commit1_free_valid,
    output commit1_free_preg,
    output flush_valid,
    input  freelist_count
  );

  modport slave (
`ifdef FREELIST_DBG_CHECK_EN
    output dbg_freelist_err,
`endif
    input  instr0_freelist_req,
    output instr0_freelist_resp,
    input  instr1_freelist_req,
    output instr1_freelist_resp,
    output freelist_can_alloc,
    input  commit0_alloc_valid,
    input  commit1_alloc_valid,
    input  commit0_free_valid,
    input  commit0_free_preg,
    input  commit1_free_valid,
    input  commit1_free_preg,
    input  flush_valid,
    output freelist_count
  );

endinterface : preg_freelist_if

// File: rtl/preg_freelist.sv
// -----------------------------------------------------------------------------
// preg_freelist
//   Circular free list of physical register tags for a 2-wide rename stage.
//   Hands out up to two free PREGs per cycle and takes back up to two released
//   PREGs per cycle at commit. A speculative head (spec_head) tracks rename,
//   a committed head (arch_head) tracks commit; a redirect copies the
//   committed head into the speculative one so the list recovers in a cycle.
//
//   Ports:
//     clock    core clock
//     reset_n  synchronous active-low reset
//     fl       preg_freelist_if.slave (alloc, release, commit, flush, status)
//
//   Pointers are log2(FL_DEPTH)+1 bits; the MSB is the wrap bit. Empty when
//   the pointers are equal, full when index bits match and wrap bits differ.
//
//   Build option: define FREELIST_DBG_CHECK_EN to add a free bitmap and the
//   sticky dbg_freelist_err flag (double free, duplicate free in one cycle,
//   alloc while the list cannot supply two tags). Alloc/release behaviour is
//   identical with or without it.
// -----------------------------------------------------------------------------
module preg_freelist #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32,
  parameter int FL_DEPTH = PREG_NUM - LREG_NUM
) (
  input  logic           clock,
  input  logic           reset_n,
  preg_freelist_if.slave fl
);

  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int IDX_W  = $clog2(FL_DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PREG_W-1:0] mem_q [FL_DEPTH];

  logic [PTR_W-1:0]  spec_head_q, spec_head_d;
  logic [PTR_W-1:0]  arch_head_q, arch_head_d;
  logic [PTR_W-1:0]  tail_q,      tail_d;

  // ---------------------------------------------------------------------------
  // Pointer views and counts
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]  spec_idx, spec_idx_p1;
  logic [IDX_W-1:0]  tail_idx, tail_idx_p1;
  logic [PTR_W-1:0]  count;
  logic              can_alloc;
  logic [PTR_W-1:0]  alloc_num, free_num, commit_num;

  assign spec_idx    = spec_head_q[IDX_W-1:0];
  assign spec_idx_p1 = spec_idx + IDX_W'(1);
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign tail_idx_p1 = tail_idx + IDX_W'(1);

  // Pointer difference modulo 2*FL_DEPTH gives the occupancy directly,
  // including the full case (FL_DEPTH) thanks to the wrap bit.
  assign count     = tail_q - spec_head_q;
  assign can_alloc = (count >= PTR_W'(2));

  assign alloc_num  = PTR_W'(fl.instr0_freelist_req) + PTR_W'(fl.instr1_freelist_req);
  assign free_num   = PTR_W'(fl.commit0_free_valid)  + PTR_W'(fl.commit1_free_valid);
  assign commit_num = PTR_W'(fl.commit0_alloc_valid) + PTR_W'(fl.commit1_alloc_valid);

  // ---------------------------------------------------------------------------
  // Responses: zero-cycle lookup. Slot1 takes the entry after slot0's only if
  // slot0 actually consumes one; otherwise it takes the head entry itself.
  // ---------------------------------------------------------------------------
  assign fl.instr0_freelist_resp = mem_q[spec_idx];
  assign fl.instr1_freelist_resp = fl.instr0_freelist_req ? mem_q[spec_idx_p1]
                                                          : mem_q[spec_idx];
  assign fl.freelist_count       = count;
  assign fl.freelist_can_alloc   = can_alloc;

  // ---------------------------------------------------------------------------
  // Release write ports: valid frees are compacted, so a lone commit1 free
  // lands at tail just like a lone commit0 free would.
  // ---------------------------------------------------------------------------
  logic              wr0_en, wr1_en;
  logic [PREG_W-1:0] wr0_data;

  assign wr0_en   = fl.commit0_free_valid | fl.commit1_free_valid;
  assign wr1_en   = fl.commit0_free_valid & fl.commit1_free_valid;
  assign wr0_data = fl.commit0_free_valid ? fl.commit0_free_preg : fl.commit1_free_preg;

  // ---------------------------------------------------------------------------
  // Next-state pointers
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default on entry, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    arch_head_d = arch_head_q + commit_num;
    tail_d      = tail_q + free_num;
    spec_head_d = spec_head_q;
    if (fl.flush_valid) begin
      // Roll back to the committed head including this cycle's commits;
      // alloc requests in a flush cycle are dropped.
      spec_head_d = arch_head_d;
    end else if (can_alloc) begin
      // Requests with can_alloc low are illegal and must not move the head.
      spec_head_d = spec_head_q + alloc_num;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments keep every register update in this block
  // order-independent; the whole state moves together at the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: the tag storage is reset on purpose: it must come up holding the
      // unmapped PREGs LREG_NUM.. so rename can start right after reset.
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= PREG_W'(LREG_NUM + i);
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= PTR_W'(FL_DEPTH);   // full: same index, wrap bit set
    end else begin
      if (wr0_en) mem_q[tail_idx]    <= wr0_data;
      if (wr1_en) mem_q[tail_idx_p1] <= fl.commit1_free_preg;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREELIST_DBG_CHECK_EN
  // ---------------------------------------------------------------------------
  // Debug checker: one bit per PREG, set while the PREG sits in the free list.
  // ---------------------------------------------------------------------------
  localparam logic [PREG_NUM-1:0] MAP_RST = {{(PREG_NUM-LREG_NUM){1'b1}}, {LREG_NUM{1'b0}}};

  logic [PREG_NUM-1:0] free_map_q, free_map_d;
  logic                dbg_err_q,  dbg_err_d;
  logic [PTR_W-1:0]    spec_dist;

  // Entries between the restored head and the old speculative head were
  // handed out on the wrong path; a flush puts them back in the free set.
  assign spec_dist = spec_head_q - arch_head_d;

  always_comb begin
    free_map_d = free_map_q;
    dbg_err_d  = dbg_err_q;

    if (fl.flush_valid) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (PTR_W'(IDX_W'(IDX_W'(i) - arch_head_d[IDX_W-1:0])) < spec_dist) begin
          free_map_d[mem_q[i]] = 1'b1;
        end
      end
    end else if (can_alloc) begin
      if (fl.instr0_freelist_req) free_map_d[fl.instr0_freelist_resp] = 1'b0;
      if (fl.instr1_freelist_req) free_map_d[fl.instr1_freelist_resp] = 1'b0;
    end

    if (fl.commit0_free_valid) begin
      if (free_map_q[fl.commit0_free_preg]) dbg_err_d = 1'b1;
      free_map_d[fl.commit0_free_preg] = 1'b1;
    end
    if (fl.commit1_free_valid) begin
      if (free_map_q[fl.commit1_free_preg]) dbg_err_d = 1'b1;
      free_map_d[fl.commit1_free_preg] = 1'b1;
    end
    if (fl.commit0_free_valid && fl.commit1_free_valid &&
        (fl.commit0_free_preg == fl.commit1_free_preg)) begin
      dbg_err_d = 1'b1;
    end
    if ((fl.instr0_freelist_req || fl.instr1_freelist_req) && !can_alloc) begin
      dbg_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      free_map_q <= MAP_RST;
      dbg_err_q  <= 1'b0;
    end else begin
      free_map_q <= free_map_d;
      dbg_err_q  <= dbg_err_d;
    end
  end

  assign fl.dbg_freelist_err = dbg_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // Occupancy can never exceed the list depth if PREGs are conserved.
  a_count_bound : assert property (@(posedge clock) disable iff (!reset_n)
    count <= PTR_W'(FL_DEPTH));

  // Without a flush, an exhausted list must hold its speculative head.
  a_no_illegal_move : assert property (@(posedge clock) disable iff (!reset_n)
    (!can_alloc && !fl.flush_valid) |=> (spec_head_q == $past(spec_head_q)));

endmodule : preg_freelist

// File: tb/tb_preg_freelist.sv
// -----------------------------------------------------------------------------
// tb_preg_freelist
//   Directed bench for preg_freelist. A table of single-cycle vectors covers
//   reset, dual/single alloc, exhaustion, illegal requests, commit + flush and
//   combined alloc/free/flush. Hand-written sequences cover pointer wrap with
//   a FIFO of expected tags and, with FREELIST_DBG_CHECK_EN, the debug flag.
// -----------------------------------------------------------------------------
module tb_preg_freelist;

  localparam int PREG_W = 6;
  localparam int CNT_W  = 6;

  logic clock;
  logic reset_n;

  preg_freelist_if #(.PREG_W(PREG_W), .CNT_W(CNT_W)) fl_if ();

  preg_freelist #(.PREG_NUM(64), .LREG_NUM(32), .FL_DEPTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fl      (fl_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       rst;
    bit       req0, req1;
    bit       ca0, ca1;
    bit       fv0;
    int       fp0;
    bit       fv1;
    int       fp1;
    bit       flush;
    bit       chk_resp;
    int       e_r0, e_r1;
    int       e_cnt;
    bit       e_can;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit r0, bit r1, bit ca0, bit ca1,
                              bit fv0, int fp0, bit fv1, int fp1, bit flush,
                              bit chk, int er0, int er1, int ecnt, bit ecan);
    vec_t v;
    v.rst = rst; v.req0 = r0; v.req1 = r1; v.ca0 = ca0; v.ca1 = ca1;
    v.fv0 = fv0; v.fp0 = fp0; v.fv1 = fv1; v.fp1 = fp1; v.flush = flush;
    v.chk_resp = chk; v.e_r0 = er0; v.e_r1 = er1; v.e_cnt = ecnt; v.e_can = ecan;
    return v;
  endfunction

  // Drive all inputs at the falling edge.
  task automatic drive(bit rst, bit r0, bit r1, bit ca0, bit ca1,
                       bit fv0, int fp0, bit fv1, int fp1, bit flush);
    @(negedge clock);
    reset_n                      = !rst;
    fl_if.instr0_freelist_req    = r0;
    fl_if.instr1_freelist_req    = r1;
    fl_if.commit0_alloc_valid    = ca0;
    fl_if.commit1_alloc_valid    = ca1;
    fl_if.commit0_free_valid     = fv0;
    fl_if.commit0_free_preg      = PREG_W'(fp0);
    fl_if.commit1_free_valid     = fv1;
    fl_if.commit1_free_preg      = PREG_W'(fp1);
    fl_if.flush_valid            = flush;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input vec_t v, input int n);
    drive(v.rst, v.req0, v.req1, v.ca0, v.ca1, v.fv0, v.fp0, v.fv1, v.fp1, v.flush);
    #1;
    if (v.chk_resp) begin
      check($sformatf("v%0d resp0", n), int'(fl_if.instr0_freelist_resp), v.e_r0);
      check($sformatf("v%0d resp1", n), int'(fl_if.instr1_freelist_resp), v.e_r1);
    end
    tick();
    check($sformatf("v%0d count", n), int'(fl_if.freelist_count), v.e_cnt);
    check($sformatf("v%0d can_alloc", n), int'(fl_if.freelist_can_alloc), int'(v.e_can));
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_q[$];
    int e0, e1;

    reset_n = 1'b0;
    fl_if.instr0_freelist_req = 0; fl_if.instr1_freelist_req = 0;
    fl_if.commit0_alloc_valid = 0; fl_if.commit1_alloc_valid = 0;
    fl_if.commit0_free_valid  = 0; fl_if.commit0_free_preg   = '0;
    fl_if.commit1_free_valid  = 0; fl_if.commit1_free_preg   = '0;
    fl_if.flush_valid         = 0;

    // ------------------------------------------------------------ table
    //                rst r0 r1 c0 c1 f0 p0 f1 p1 fl chk r0  r1  cnt can
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  32, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32, 32, 32, 1));
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 30 + 2*k, 31 + 2*k, 32 - 2*k, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 62, 63, 0,  0));
    // illegal dual request on an empty list: stale wrapped entries, no move
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32, 33, 0,  0));
    // reset mid-operation, then slot1-only request takes the head entry
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  32, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32, 32, 31, 1));
    // alloc 4, commit 2, flush -> head back to entry 2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  32, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32, 33, 30, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 34, 35, 28, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 36, 36, 28, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 36, 36, 30, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 34, 34, 30, 1));
    // flush together with a commit: restore to committed head + 1
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 34, 35, 28, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 36, 36, 29, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 35, 35, 29, 1));
    // dual alloc + dual free + flush: allocs dropped, frees kept
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 35, 36, 31, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 35, 35, 31, 1));
    // slot0 alloc with a commit1-only free: net zero
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1, 35, 36, 31, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 36, 36, 31, 1));

    foreach (tbl[i]) apply(tbl[i], i);

    // ------------------------------------------------- wrap sequence
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    check("drain count", int'(fl_if.freelist_count), 0);
    drive(0, 0, 0, 0, 0, 1, 5, 1, 7, 0);
    tick();
    check("free57 count", int'(fl_if.freelist_count), 2);
    check("free57 can_alloc", int'(fl_if.freelist_can_alloc), 1);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("free57 resp0", int'(fl_if.instr0_freelist_resp), 5);
    check("free57 resp1", int'(fl_if.instr1_freelist_resp), 7);
    tick();
    check("free57 drained", int'(fl_if.freelist_count), 0);

    // Lone commit1 free, then 15 pairs; the last pair straddles index 31->0.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    exp_q.push_back(0);
    e0 = -1;
    for (int t = 1; t <= 32; t++) begin
      if (t == 5 || t == 7) continue;
      if (e0 < 0) begin
        e0 = t;
      end else begin
        drive(0, 0, 0, 0, 0, 1, e0, 1, t, 0);
        tick();
        exp_q.push_back(e0);
        exp_q.push_back(t);
        e0 = -1;
      end
    end
    check("refill count", int'(fl_if.freelist_count), 31);

    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e1 = exp_q.pop_front();
    check("wrap single resp1", int'(fl_if.instr1_freelist_resp), e1);
    tick();
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      if (k == 0 || k == 14) begin
        check($sformatf("wrap pair%0d resp0", k), int'(fl_if.instr0_freelist_resp), e0);
        check($sformatf("wrap pair%0d resp1", k), int'(fl_if.instr1_freelist_resp), e1);
      end else begin
        checks++;
        if (int'(fl_if.instr0_freelist_resp) != e0 || int'(fl_if.instr1_freelist_resp) != e1) begin
          errors++;
          $display("FAIL wrap pair%0d: got %0d/%0d expected %0d/%0d", k,
                   fl_if.instr0_freelist_resp, fl_if.instr1_freelist_resp, e0, e1);
        end
      end
      tick();
    end
    check("wrap last tags 31/32", e0 * 100 + e1, 3132);
    check("wrap end count", int'(fl_if.freelist_count), 0);
    check("wrap end can_alloc", int'(fl_if.freelist_can_alloc), 0);

`ifdef FREELIST_DBG_CHECK_EN
    // ------------------------------------------------- debug checker
    do_reset();
    check("dbg reset", int'(fl_if.dbg_freelist_err), 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("dbg legal alloc", int'(fl_if.dbg_freelist_err), 0);
    drive(0, 0, 0, 0, 0, 1, 40, 0, 0, 0);
    tick();
    check("dbg free 40 already free", int'(fl_if.dbg_freelist_err), 1);
    idle_cycle();
    check("dbg sticky", int'(fl_if.dbg_freelist_err), 1);

    do_reset();
    check("dbg reset2", int'(fl_if.dbg_freelist_err), 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32, 0, 0, 0);
    tick();
    check("dbg legal free 32", int'(fl_if.dbg_freelist_err), 0);
    drive(0, 0, 0, 0, 0, 1, 32, 0, 0, 0);
    tick();
    check("dbg double free 32", int'(fl_if.dbg_freelist_err), 1);

    do_reset();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 33, 1, 33, 0);
    tick();
    check("dbg same preg both slots", int'(fl_if.dbg_freelist_err), 1);
`endif

    idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_preg_freelist
